// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel PWM on one shared prescaled timebase; define PWM_SHADOW_EN to double-buffer configuration onto period boundaries
module pwm_gen_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pwm_en,
  input  logic [7:0]                prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [WIDTH*CHANNELS-1:0] compare1,
  input  logic [WIDTH*CHANNELS-1:0] compare2,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [WIDTH-1:0]          count_val,
  output logic                      period_tick,
  output logic [CHANNELS-1:0]       pwm_out
);
  logic [7:0]                prescale_act;
  logic [WIDTH-1:0]          period_act;
  logic [2*CHANNELS-1:0]     mode_act;
  logic [WIDTH*CHANNELS-1:0] cmp1_act;
  logic [WIDTH*CHANNELS-1:0] cmp2_act;
  logic [CHANNELS-1:0]       pol_act;
  logic [7:0]                pre_cnt_q, pre_cnt_d;
  logic                      tick_q, tick_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic                      period_tick_q, period_tick_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic [CHANNELS-1:0]       raw;
  logic                      wrap;
  // The tick is registered so the first enabled edge never advances the counter
  assign wrap = tick_q && count_q == period_act;
`ifdef PWM_SHADOW_EN
  logic [7:0]                prescale_q;
  logic [WIDTH-1:0]          period_q;
  logic [2*CHANNELS-1:0]     mode_q;
  logic [WIDTH*CHANNELS-1:0] cmp1_q;
  logic [WIDTH*CHANNELS-1:0] cmp2_q;
  logic [CHANNELS-1:0]       pol_q;
  // Shadow copies track the inputs while idle and refresh only on the wrap edge while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prescale_q <= '0;
      period_q   <= '0;
      mode_q     <= '0;
      cmp1_q     <= '0;
      cmp2_q     <= '0;
      pol_q      <= '0;
    end else if (!pwm_en || wrap) begin
      prescale_q <= prescale;
      period_q   <= period;
      mode_q     <= mode;
      cmp1_q     <= compare1;
      cmp2_q     <= compare2;
      pol_q      <= polarity;
    end
  assign prescale_act = prescale_q;
  assign period_act   = period_q;
  assign mode_act     = mode_q;
  assign cmp1_act     = cmp1_q;
  assign cmp2_act     = cmp2_q;
  assign pol_act      = pol_q;
`else
  assign prescale_act = prescale;
  assign period_act   = period;
  assign mode_act     = mode;
  assign cmp1_act     = compare1;
  assign cmp2_act     = compare2;
  assign pol_act      = polarity;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] c1, c2;
    logic [1:0]       m;
    assign c1 = cmp1_act[WIDTH*i +: WIDTH];
    assign c2 = cmp2_act[WIDTH*i +: WIDTH];
    assign m  = mode_act[2*i +: 2];
    assign raw[i] = m == 2'd0 ? count_q < c1 :
                    m == 2'd1 ? count_q >= c1 :
                    m == 2'd2 ? count_q >= c1 && count_q < c2 : 1'b0;
  end
  // Next state of prescaler, counter, wrap pulse and outputs; disable clears the timebase
  always_comb begin
    pre_cnt_d     = !pwm_en || pre_cnt_q == prescale_act ? 8'd0 : pre_cnt_q + 8'd1;
    tick_d        = pwm_en && pre_cnt_q == prescale_act;
    count_d       = !pwm_en || wrap ? '0 : tick_q ? count_q + 1'b1 : count_q;
    period_tick_d = pwm_en && wrap;
    pwm_d         = pwm_en ? raw ^ pol_act : polarity;
  end
  // Timebase and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      tick_q        <= 1'b0;
      count_q       <= '0;
      period_tick_q <= 1'b0;
      pwm_q         <= '0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      tick_q        <= tick_d;
      count_q       <= count_d;
      period_tick_q <= period_tick_d;
      pwm_q         <= pwm_d;
    end
  assign count_val   = count_q;
  assign period_tick = period_tick_q;
  assign pwm_out     = pwm_q;
endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Parametrised multi-channel PWM generator with an internal prescaled timebase. It drives CHANNELS outputs from one shared counter. Each channel has its own alignment mode, two compare values and a polarity bit. When enabled, configuration is double-buffered so that updates land only on period boundaries. The block sits between the register file and the top-level pins and replaces the single-channel generator that needed an external counter.

## Interface
- WIDTH, 16: counter, period and compare width (2..32).
- CHANNELS, 4: number of PWM outputs (1..16).
- clk  input  1  peripheral clock.
- rst_n  input  1  asynchronous, active-low reset.
- pwm_en  input  1  global enable; low stops and clears the timebase and idles the outputs.
- prescale  input  8  timebase advances once every prescale+1 clk cycles.
- period  input  WIDTH  counter terminal value; counter runs 0..period.
- mode  input  2*CHANNELS  per channel, bits [2i+1:2i]: 00 left, 01 right, 10 window, 11 reserved.
- compare1  input  WIDTH*CHANNELS  per-channel compare 1, slice [WIDTH*i +: WIDTH].
- compare2  input  WIDTH*CHANNELS  per-channel compare 2, used in window mode only.
- polarity  input  CHANNELS  1 inverts the channel output; this is also the idle level.
- count_val  output  WIDTH  current timebase value.
- period_tick  output  1  one-cycle pulse in the cycle count_val becomes 0 by wrap.
- pwm_out  output  CHANNELS  PWM outputs.

## Operation
- Prescaler pre_cnt (8 bit):
  - When pwm_en=1: if pre_cnt==prescale_act, then pre_cnt<=0 and tick=1; else pre_cnt<=pre_cnt+1.
- Counter, on tick:
  - If count_val==period_act, count_val<=0 and period_tick<=1 (wrap).
  - Else count_val<=count_val+1.
  - No tick: count holds; period_tick<=0.
- pwm_en=0: pre_cnt, count_val and period_tick are cleared synchronously. pwm_out[i]<=polarity[i], the raw input.
- Raw channel level, with c=count_val and active config:
  - left: c < cmp1.
  - right: c >= cmp1.
  - window: cmp1 <= c < cmp2. The output stays low if cmp1 >= cmp2.
  - reserved: 0.
- pwm_out[i] <= raw[i] ^ pol_act[i], registered.
- Unsigned arithmetic throughout; no saturation.
- Boundary values:
  - left: cmp1=0 gives 0% duty; cmp1 > period gives 100%.
  - right: cmp1=0 gives 100%; cmp1 > period gives 0%.
- period=0: every tick is a wrap; count_val stays 0 and period_tick pulses once per tick.
- Active config is period_act, prescale_act, mode_act, cmp1_act, cmp2_act and pol_act (see Configuration).

## Timing
- Reset values: count_val=0, period_tick=0, pwm_out=0, pre_cnt=0, all active registers 0.
- First cycle after reset with pwm_en=0: pwm_out=polarity.
- Enable: on the first clk edge with pwm_en=1, count_val stays 0 and pre_cnt counts from 0.
  - With prescale=0, count_val=1 after the second enabled edge.
- pwm_out lags count_val by exactly one clk cycle. It reflects the count_val value held during the previous cycle.
- period_tick is registered and coincides with the count_val=0 cycle after a wrap. It is not asserted on enable.
- Disable mid-period takes effect on the next edge. There is no completion of the current period.
- Asynchronous reset mid-operation clears everything immediately, regardless of clk.

## Configuration
- PWM_SHADOW_EN defined:
  - All active registers are shadow copies.
  - They load from the inputs on every edge while pwm_en=0.
  - While enabled, they load only on the wrap edge (tick and count_val==period_act). The new values govern the count_val=0 cycle onward.
  - Input changes mid-period have no effect until the next wrap.
- PWM_SHADOW_EN undefined:
  - Active values are the inputs directly.
  - Changes affect the next clk edge; glitches and shortened periods are permitted.

## Test plan
- Left mode: period=9, prescale=0, cmp1=3, pol=0, enable. pwm_out[0] is high 3 cycles and low 7 per 10-cycle period. period_tick pulses every 10 cycles.
- Right and window modes together: ch1 right with cmp1=7; ch2 window with cmp1=2, cmp2=5; period=9. ch1 is high at counts 7..9. ch2 is high at counts 2..4, one cycle after each count. ch3 reserved stays low.
- Prescale=2, period=3: count_val advances every 3 clk cycles, so period_tick comes every 12 cycles. Polarity=1 on ch0 with cmp1=1 gives a low 3-cycle pulse per period.
- Shadow (macro on): mid-period, change cmp1 from 3 to 6 and period from 9 to 4. The current period completes at the old values; the next period is 5 counts with 100% duty, since cmp1 > period. With the macro off, the change applies on the next edge.
- Boundaries: cmp1=0 in left gives constant 0. cmp1=10 with period=9 gives constant 1. Window with cmp1=cmp2 gives constant 0. period=0 gives period_tick on every tick.
- Control:
  - Drop pwm_en mid-period: next edge count_val=0, outputs=polarity. Re-enable restarts from 0.
  - Assert rst_n low mid-period: count_val, period_tick and pwm_out go to 0 asynchronously.
